// File: rtl/spi_slave_if_if.sv
// Bus between the SPI slave front-end, the external SPI master pins and the RAM port.
interface spi_slave_if_if #(
    parameter int WORD_SIZE = 8
);
    logic                 ss_n;
    logic                 mosi;
    logic                 miso;
    logic [WORD_SIZE+1:0] rx_data;
    logic                 rx_valid;
    logic [WORD_SIZE-1:0] tx_data;
    logic                 tx_valid;

    modport slave (
        input  ss_n, mosi, tx_data, tx_valid,
        output miso, rx_data, rx_valid
    );

    modport master (
        output ss_n, mosi, tx_data, tx_valid,
        input  miso, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave front-end: deserialises 10-bit RAM commands from MOSI and
// serialises the RAM read word back on MISO, all on the rising SPI clock.
module spi_slave_if #(
    parameter int WORD_SIZE = 8
) (
    input  logic             clk,
    input  logic             arst,
    spi_slave_if_if.slave    bus
);
    localparam int CW    = WORD_SIZE + 2;
    localparam int CNT_W = $clog2(CW + 1);
    localparam int TXC_W = $clog2(WORD_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CW-2:0]        rx_shift;
    logic [CW-1:0]        rx_data_q;
    logic                 rx_valid_q;
    logic                 miso_q;
    logic                 rd_addr_held;
    logic [WORD_SIZE-2:0] tx_shift;
    logic [TXC_W-1:0]     tx_cnt;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 in_word;
    logic                 word_done;
    logic                 tx_load;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_word   = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
        word_done = 1'b0;
        tx_load   = 1'b0;
        if (bus.ss_n) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = CHK_CMD;
                CHK_CMD: begin
                    if (!bus.mosi)        state_nxt = WRITE;
                    else if (rd_addr_held) state_nxt = READ_DATA;
                    else                   state_nxt = READ_ADD;
                end
                default: state_nxt = state;
            endcase
            word_done = in_word && (bit_cnt == CNT_W'(CW - 1));
            // Read data is only accepted once, after the command word is out.
            tx_load   = (state == READ_DATA) && (bit_cnt == CNT_W'(CW)) &&
                        !tx_busy && !tx_done && bus.tx_valid;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            bit_cnt      <= '0;
            rx_shift     <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            miso_q       <= 1'b0;
            rd_addr_held <= 1'b0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (bus.ss_n) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_cnt   <= '0;
                tx_busy  <= 1'b0;
                tx_done  <= 1'b0;
                miso_q   <= 1'b0;
            end else begin
                if (state == CHK_CMD) begin
                    rx_shift <= {{(CW-2){1'b0}}, bus.mosi};
                    bit_cnt  <= CNT_W'(1);
                end else if (in_word && (bit_cnt < CNT_W'(CW))) begin
                    rx_shift <= {rx_shift[CW-3:0], bus.mosi};
                    bit_cnt  <= bit_cnt + CNT_W'(1);
                end

                if (word_done) begin
                    rx_data_q  <= {rx_shift, bus.mosi};
                    rx_valid_q <= 1'b1;
                    if (state == READ_ADD)       rd_addr_held <= 1'b1;
                    else if (state == READ_DATA) rd_addr_held <= 1'b0;
                end

                // MSB goes straight to miso; the shifter keeps only the rest.
                if (tx_load) begin
                    tx_shift <= bus.tx_data[WORD_SIZE-2:0];
                    miso_q   <= bus.tx_data[WORD_SIZE-1];
                    tx_cnt   <= TXC_W'(WORD_SIZE - 1);
                    tx_busy  <= 1'b1;
                end else if (tx_busy) begin
                    if (tx_cnt != '0) begin
                        miso_q   <= tx_shift[WORD_SIZE-2];
                        tx_shift <= tx_shift << 1;
                        tx_cnt   <= tx_cnt - TXC_W'(1);
                    end else begin
                        miso_q  <= 1'b0;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.miso     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: table of command frames plus abort,
// async-reset and idle corner sequences, with a one-cycle-latency RAM model.
module tb_spi_slave_if;
    logic clk = 1'b0;
    logic arst;

    spi_slave_if_if #(.WORD_SIZE(8)) bus ();

    spi_slave_if #(.WORD_SIZE(8)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         f_rx_cnt;
    int         f_rx_edge;
    logic [9:0] f_rx_got;
    logic [7:0] f_mbits;
    logic       f_mother;
    logic       f_tail;

    typedef struct {
        logic [9:0] word;
        logic [7:0] txw;
        bit         spur;
        logic [9:0] exp_rx;
        logic [7:0] exp_miso;
        bit         exp_held;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One frame: edge 1 samples ss_n low, edges 2..11 carry bits 9..0,
    // RAM answers a read-data opcode two edges after rx_valid is seen.
    task automatic frame(input logic [9:0] w, input logic [7:0] txw, input bit spur, input int cut);
        int resp_at;
        resp_at   = -1;
        f_rx_cnt  = 0;
        f_rx_edge = 0;
        f_rx_got  = '0;
        f_mbits   = '0;
        f_mother  = 1'b0;
        f_tail    = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            bus.ss_n     = 1'b0;
            bus.mosi     = (k >= 2 && k <= 11) ? w[11-k] : 1'($urandom);
            bus.tx_valid = spur || (k == resp_at);
            bus.tx_data  = spur ? 8'hFF : txw;
            @(posedge clk);
            @(negedge clk);
            if (bus.rx_valid) begin
                f_rx_cnt++;
                f_rx_edge = k;
                f_rx_got  = bus.rx_data;
                if (bus.rx_data[9:8] == 2'b11 && !spur) resp_at = k + 2;
            end
            if (k >= 13 && k <= 20) f_mbits[20-k] = bus.miso;
            else                    f_mother = f_mother | bus.miso;
            if (k == cut) return;
        end
        bus.ss_n     = 1'b1;
        bus.tx_valid = 1'b0;
        bus.mosi     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        f_tail = bus.miso | bus.rx_valid;
    endtask

    task automatic check_frame(input string tag, input logic [9:0] exp_rx,
                               input logic [7:0] exp_miso, input bit exp_held);
        chk({tag, ".rx_pulses"}, f_rx_cnt, 1);
        chk({tag, ".rx_edge"},   f_rx_edge, 11);
        chk({tag, ".rx_data"},   {22'd0, f_rx_got}, {22'd0, exp_rx});
        chk({tag, ".miso_bits"}, {24'd0, f_mbits}, {24'd0, exp_miso});
        chk({tag, ".miso_idle"}, {31'd0, f_mother}, 32'd0);
        chk({tag, ".tail"},      {31'd0, f_tail}, 32'd0);
        chk({tag, ".held"},      {31'd0, dut.rd_addr_held}, {31'd0, exp_held});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{10'h0A5, 8'h00, 1'b0, 10'h0A5, 8'h00, 1'b0};
        vecs[1]  = '{10'h13C, 8'h00, 1'b0, 10'h13C, 8'h00, 1'b0};
        vecs[2]  = '{10'h2A5, 8'h00, 1'b0, 10'h2A5, 8'h00, 1'b1};
        vecs[3]  = '{10'h3FF, 8'h3C, 1'b0, 10'h3FF, 8'h3C, 1'b0};
        vecs[4]  = '{10'h3A5, 8'h55, 1'b0, 10'h3A5, 8'h00, 1'b1};
        vecs[5]  = '{10'h300, 8'hA5, 1'b0, 10'h300, 8'hA5, 1'b0};
        vecs[6]  = '{10'h0FF, 8'h00, 1'b1, 10'h0FF, 8'h00, 1'b0};
        vecs[7]  = '{10'h2FF, 8'h00, 1'b0, 10'h2FF, 8'h00, 1'b1};
        vecs[8]  = '{10'h3C3, 8'h81, 1'b0, 10'h3C3, 8'h81, 1'b0};
        vecs[9]  = '{10'h1C3, 8'h00, 1'b0, 10'h1C3, 8'h00, 1'b0};
        vecs[10] = '{10'h200, 8'h00, 1'b0, 10'h200, 8'h00, 1'b1};
        vecs[11] = '{10'h155, 8'h00, 1'b1, 10'h155, 8'h00, 1'b1};
        vecs[12] = '{10'h3E7, 8'h96, 1'b0, 10'h3E7, 8'h96, 1'b0};

        arst         = 1'b1;
        bus.ss_n     = 1'b1;
        bus.mosi     = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset.miso",     {31'd0, bus.miso}, 32'd0);
        chk("reset.rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("reset.rx_data",  {22'd0, bus.rx_data}, 32'd0);
        chk("reset.held",     {31'd0, dut.rd_addr_held}, 32'd0);
        arst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            frame(vecs[i].word, vecs[i].txw, vecs[i].spur, 0);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_rx, vecs[i].exp_miso, vecs[i].exp_held);
        end

        // Spurious tx_valid while deselected.
        bus.ss_n     = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle_spur.miso", {31'd0, bus.miso}, 32'd0);
        end
        bus.tx_valid = 1'b0;
        frame(10'h0C3, 8'h00, 1'b0, 0);
        check_frame("idle_spur.next", 10'h0C3, 8'h00, 1'b0);

        // Abort a READ_ADD frame after 5 bits, then back-to-back read frame.
        frame(10'h2A5, 8'h00, 1'b0, 6);
        chk("abort.rx_pulses", f_rx_cnt, 0);
        bus.ss_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort.rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("abort.held",     {31'd0, dut.rd_addr_held}, 32'd0);
        frame(10'h3AA, 8'h77, 1'b0, 0);
        check_frame("abort.next", 10'h3AA, 8'h00, 1'b1);

        // Abort a READ_DATA frame: the held address survives.
        frame(10'h3FF, 8'h5A, 1'b0, 8);
        bus.ss_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_rd.held", {31'd0, dut.rd_addr_held}, 32'd1);
        frame(10'h3FF, 8'h5A, 1'b0, 0);
        check_frame("abort_rd.next", 10'h3FF, 8'h5A, 1'b0);

        // Async reset in the middle of serialising 0xFF.
        frame(10'h200, 8'h00, 1'b0, 0);
        check_frame("rst.setup", 10'h200, 8'h00, 1'b1);
        frame(10'h3FF, 8'hFF, 1'b0, 15);
        chk("rst.pre_bits", {29'd0, f_mbits[7:5]}, 32'h7);
        #2 arst = 1'b1;
        #1;
        chk("rst.miso",     {31'd0, bus.miso}, 32'd0);
        chk("rst.rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("rst.rx_data",  {22'd0, bus.rx_data}, 32'd0);
        chk("rst.held",     {31'd0, dut.rd_addr_held}, 32'd0);
        bus.ss_n     = 1'b1;
        bus.tx_valid = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        frame(10'h3AA, 8'h77, 1'b0, 0);
        check_frame("rst.next", 10'h3AA, 8'h00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
